// File: rtl/dl_probe_scheduler.sv
// dl_probe_scheduler
//   Picks one blocked dataflow process at a time, round-robin, as the origin
//   of a deadlock probe on the detect ring. Each probe lasts a bounded window,
//   and a token_clear pulse follows it. When the origin's own token returns,
//   the block latches a sticky deadlock report and reports the origin index.
//
//   Optional feature macro: DL_PROBE_STATS_EN
//     defined   : probe_cnt / timeout_cnt are saturating 16-bit counters
//     undefined : both counters are removed and the ports read 0
//
// Ports
//   dl_clock       clock
//   dl_reset       asynchronous, active-low reset
//   all_finish     design finished; suppresses probing and detection
//   blk_vec        per-process blocked flags
//   dl_in_vec      per-unit token-returned flags
//   origin         one-hot probe origin, zero when no probe is active
//   token_clear    one-cycle pulse clearing all ring tokens
//   dl_detect_out  sticky deadlock flag
//   dl_proc        index of the origin that detected the deadlock
//   probe_cnt      probes issued
//   timeout_cnt    probes ended by window expiry
module dl_probe_scheduler #(
    parameter int unsigned N_PROC       = 3,
    parameter int unsigned PROBE_CYCLES = 16,
    parameter int unsigned IDX_W        = 2
) (
    input  logic              dl_clock,
    input  logic              dl_reset,
    input  logic              all_finish,
    input  logic [N_PROC-1:0] blk_vec,
    input  logic [N_PROC-1:0] dl_in_vec,
    output logic [N_PROC-1:0] origin,
    output logic              token_clear,
    output logic              dl_detect_out,
    output logic [IDX_W-1:0]  dl_proc,
    output logic [15:0]       probe_cnt,
    output logic [15:0]       timeout_cnt
);

    localparam int unsigned TMR_W = (PROBE_CYCLES > 2) ? $clog2(PROBE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PROBE,
        S_CLEAR,
        S_DETECTED
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   pick_q, pick_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [N_PROC-1:0]  origin_q, origin_d;
    logic               token_clear_q, token_clear_d;
    logic               detect_q, detect_d;
    logic [IDX_W-1:0]   proc_q, proc_d;

    logic               scan_hit;
    logic [IDX_W-1:0]   scan_idx;
    int unsigned        cand;

`ifdef DL_PROBE_STATS_EN
    logic [15:0]        probe_cnt_q, probe_cnt_d;
    logic [15:0]        timeout_cnt_q, timeout_cnt_d;
`endif

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            pick_q        <= '0;
            tmr_q         <= '0;
            origin_q      <= '0;
            token_clear_q <= 1'b0;
            detect_q      <= 1'b0;
            proc_q        <= '0;
`ifdef DL_PROBE_STATS_EN
            probe_cnt_q   <= '0;
            timeout_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pick_q        <= pick_d;
            tmr_q         <= tmr_d;
            origin_q      <= origin_d;
            token_clear_q <= token_clear_d;
            detect_q      <= detect_d;
            proc_q        <= proc_d;
`ifdef DL_PROBE_STATS_EN
            probe_cnt_q   <= probe_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        pick_d        = pick_q;
        tmr_d         = tmr_q;
        origin_d      = origin_q;
        token_clear_d = 1'b0;
        detect_d      = detect_q;
        proc_d        = proc_q;
`ifdef DL_PROBE_STATS_EN
        probe_cnt_d   = probe_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
`endif

        // Round-robin scan starting at ptr, wrapping at N_PROC-1.
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = 0;
        for (int unsigned i = 0; i < N_PROC; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_PROC) begin
                cand = cand - N_PROC;
            end
            if (!scan_hit && blk_vec[cand[IDX_W-1:0]]) begin
                scan_hit = 1'b1;
                scan_idx = cand[IDX_W-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                origin_d = '0;
                if (!all_finish && (|blk_vec)) begin
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                if (scan_hit) begin
                    pick_d   = scan_idx;
                    ptr_d    = (32'(scan_idx) == N_PROC - 1) ? '0 : scan_idx + 1'b1;
                    tmr_d    = TMR_W'(PROBE_CYCLES - 1);
                    origin_d = N_PROC'(1) << scan_idx;
                    state_d  = S_PROBE;
`ifdef DL_PROBE_STATS_EN
                    if (probe_cnt_q != 16'hFFFF) begin
                        probe_cnt_d = probe_cnt_q + 16'd1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_PROBE: begin
                tmr_d = tmr_q - 1'b1;
                // Exit priority: finish, token return, unblock, window expiry.
                if (all_finish) begin
                    state_d       = S_CLEAR;
                    origin_d      = '0;
                    token_clear_d = 1'b1;
                end else if (dl_in_vec[pick_q]) begin
                    state_d  = S_DETECTED;
                    detect_d = 1'b1;
                    proc_d   = pick_q;
                end else if (!blk_vec[pick_q]) begin
                    state_d       = S_CLEAR;
                    origin_d      = '0;
                    token_clear_d = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d       = S_CLEAR;
                    origin_d      = '0;
                    token_clear_d = 1'b1;
`ifdef DL_PROBE_STATS_EN
                    if (timeout_cnt_q != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
`endif
                end
            end

            S_CLEAR: begin
                origin_d = '0;
                state_d  = S_IDLE;
            end

            S_DETECTED: begin
                state_d = S_DETECTED;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign origin        = origin_q;
    assign token_clear   = token_clear_q;
    assign dl_detect_out = detect_q;
    assign dl_proc       = proc_q;

`ifdef DL_PROBE_STATS_EN
    assign probe_cnt     = probe_cnt_q;
    assign timeout_cnt   = timeout_cnt_q;
`else
    assign probe_cnt     = '0;
    assign timeout_cnt   = '0;
`endif

endmodule

// File: tb/tb_dl_probe_scheduler.sv
// tb_dl_probe_scheduler
//   Bench for dl_probe_scheduler (N_PROC=3, PROBE_CYCLES=16). Expected outputs
//   come from a transaction-level model: a probe is a countdown of remaining
//   window cycles, surrounded by "arming" and "clearing" steps.
`timescale 1ns/1ps
module tb_dl_probe_scheduler;

    localparam int unsigned NP = 3;
    localparam int unsigned PC = 16;
    localparam int unsigned IW = 2;

    logic          dl_clock   = 1'b0;
    logic          dl_reset   = 1'b1;
    logic          all_finish = 1'b0;
    logic [NP-1:0] blk_vec    = '0;
    logic [NP-1:0] dl_in_vec  = '0;
    logic [NP-1:0] origin;
    logic          token_clear;
    logic          dl_detect_out;
    logic [IW-1:0] dl_proc;
    logic [15:0]   probe_cnt;
    logic [15:0]   timeout_cnt;

    dl_probe_scheduler #(
        .N_PROC       (NP),
        .PROBE_CYCLES (PC),
        .IDX_W        (IW)
    ) dut (
        .dl_clock      (dl_clock),
        .dl_reset      (dl_reset),
        .all_finish    (all_finish),
        .blk_vec       (blk_vec),
        .dl_in_vec     (dl_in_vec),
        .origin        (origin),
        .token_clear   (token_clear),
        .dl_detect_out (dl_detect_out),
        .dl_proc       (dl_proc),
        .probe_cnt     (probe_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 dl_clock = ~dl_clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model
    int m_ptr, m_pick, m_left, m_probes, m_touts;
    bit m_clearing, m_arming, m_dead;

    task automatic model_reset();
        m_ptr = 0; m_pick = 0; m_left = 0; m_probes = 0; m_touts = 0;
        m_clearing = 0; m_arming = 0; m_dead = 0;
    endtask

    task automatic end_probe(input bit expired);
        m_left     = 0;
        m_clearing = 1;
        if (expired && m_touts < 65535) m_touts++;
    endtask

    task automatic model_step(input logic af, input logic [NP-1:0] blk, input logic [NP-1:0] din);
        if (m_dead) return;
        if (m_left > 0) begin
            if (af) end_probe(0);
            else if (din[m_pick]) begin m_dead = 1; m_left = 0; end
            else if (!blk[m_pick]) end_probe(0);
            else if (m_left == 1) end_probe(1);
            else m_left--;
        end else if (m_clearing) begin
            m_clearing = 0;
        end else if (m_arming) begin
            m_arming = 0;
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_ptr + k) % NP;
                if (blk[i]) begin
                    m_pick = i;
                    m_ptr  = (i + 1) % NP;
                    m_left = PC;
                    if (m_probes < 65535) m_probes++;
                    break;
                end
            end
        end else if (!af && blk != 0) begin
            m_arming = 1;
        end
    endtask

    function automatic logic [31:0] exp_origin();
        return (m_left > 0 || m_dead) ? (32'd1 << m_pick) : 32'd0;
    endfunction

    task automatic check_outputs();
        check_val("origin", 32'(origin), exp_origin());
        check_val("token_clear", 32'(token_clear), 32'(m_clearing));
        check_val("dl_detect_out", 32'(dl_detect_out), 32'(m_dead));
        check_val("dl_proc", 32'(dl_proc), m_dead ? 32'(m_pick) : 32'd0);
`ifdef DL_PROBE_STATS_EN
        check_val("probe_cnt", 32'(probe_cnt), 32'(m_probes));
        check_val("timeout_cnt", 32'(timeout_cnt), 32'(m_touts));
`else
        check_val("probe_cnt", 32'(probe_cnt), 32'd0);
        check_val("timeout_cnt", 32'(timeout_cnt), 32'd0);
`endif
    endtask

    // Called at a negedge: drive inputs, advance model, check after next posedge.
    task automatic cycle(input logic af, input logic [NP-1:0] blk, input logic [NP-1:0] din);
        all_finish = af;
        blk_vec    = blk;
        dl_in_vec  = din;
        model_step(af, blk, din);
        @(negedge dl_clock);
        check_outputs();
    endtask

    task automatic apply_reset();
        all_finish = 1'b0;
        blk_vec    = '0;
        dl_in_vec  = '0;
        dl_reset   = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge dl_clock);
        dl_reset = 1'b1;
    endtask

    task automatic wait_probe(input int p, input logic af, input logic [NP-1:0] blk);
        for (int k = 0; k < 8 && !(m_left > 0 && m_pick == p); k++) cycle(af, blk, '0);
        check_val("probe_start", 32'(origin), 32'd1 << p);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NP-1:0] rblk, rdin;
        logic          raf;
        int            cnt;
        logic [NP-1:0] rr_seen [4];
        logic [NP-1:0] prev;
        int            nseen;

        @(negedge dl_clock);

        // Single blocked process: 16-cycle window, clear, re-probe
        apply_reset();
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b0, 3'b010, '0);
            if (token_clear) break;
            if (origin == 3'b010) cnt++;
        end
        check_val("window_len", 32'(cnt), 32'(PC));
        for (int c = 0; c < 24; c++) cycle(1'b0, 3'b010, '0);

        // Round-robin order
        apply_reset();
        for (int k = 0; k < 4; k++) rr_seen[k] = '0;
        prev  = '0;
        nseen = 0;
        for (int c = 0; c < 100 && nseen < 4; c++) begin
            cycle(1'b0, 3'b111, '0);
            if (origin != '0 && prev == '0) begin
                rr_seen[nseen] = origin;
                nseen++;
            end
            prev = origin;
        end
        check_val("rr_0", 32'(rr_seen[0]), 32'd1);
        check_val("rr_1", 32'(rr_seen[1]), 32'd2);
        check_val("rr_2", 32'(rr_seen[2]), 32'd4);
        check_val("rr_3", 32'(rr_seen[3]), 32'd1);

        // Deadlock on the 5th probe cycle of process 1
        apply_reset();
        wait_probe(1, 1'b0, 3'b110);
        for (int c = 0; c < 4; c++) cycle(1'b0, 3'b110, '0);
        cycle(1'b0, 3'b110, 3'b010);
        check_val("dl_detect", 32'(dl_detect_out), 32'd1);
        check_val("dl_proc_1", 32'(dl_proc), 32'd1);
        check_val("dl_origin", 32'(origin), 32'(3'b010));
        for (int c = 0; c < 10; c++) cycle(1'b1, '0, '0);
        check_val("dl_hold", 32'(origin), 32'(3'b010));
        check_val("dl_sticky", 32'(dl_detect_out), 32'd1);

        // Unblock mid-probe
        apply_reset();
        wait_probe(0, 1'b0, 3'b001);
        cycle(1'b0, 3'b001, '0);
        cycle(1'b0, 3'b001, '0);
        cycle(1'b0, 3'b000, '0);
        check_val("unblock_clear", 32'(token_clear), 32'd1);
        for (int c = 0; c < 4; c++) cycle(1'b0, 3'b000, '0);

        // all_finish together with token return
        apply_reset();
        wait_probe(2, 1'b0, 3'b100);
        cycle(1'b0, 3'b100, '0);
        cycle(1'b1, 3'b100, 3'b100);
        check_val("af_clear", 32'(token_clear), 32'd1);
        check_val("af_nodetect", 32'(dl_detect_out), 32'd0);
        for (int c = 0; c < 20; c++) cycle(1'b1, 3'b111, '0);
        check_val("af_noprobe", 32'(origin), 32'd0);

        // Reset at probe cycle 7
        apply_reset();
        wait_probe(0, 1'b0, 3'b111);
        for (int c = 0; c < 6; c++) cycle(1'b0, 3'b111, '0);
        apply_reset();
        wait_probe(0, 1'b0, 3'b111);
        for (int c = 0; c < 20; c++) cycle(1'b0, 3'b111, '0);

        // Randomised episodes
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            rblk = NP'($urandom);
            raf  = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 7) == 0) rblk = NP'($urandom);
                if ($urandom_range(0, 39) == 0) raf = ~raf;
                rdin = ($urandom_range(0, 119) == 0) ? NP'($urandom) : '0;
                cycle(raf, rblk, rdin);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dl_probe_scheduler.md
# dl_probe_scheduler

Simulation-side scheduler for the dataflow deadlock-detection ring of the PFB multichannel decimator (read_inputs → compute_pfb → write_outputs). It watches per-process blocked flags and picks one blocked process at a time, round-robin, as probe origin. It holds that origin for a bounded probe window, then clears the tokens between probes. It latches and reports a deadlock when the origin's own token returns.

## Interface
Parameters:
- N_PROC, 3, number of dataflow processes (detect units) on the ring
- PROBE_CYCLES, 16, probe window length in cycles (≥2)
- IDX_W, 2, width of the process index; must satisfy 2^IDX_W ≥ N_PROC

Ports:
- dl_clock  in  1  clock
- dl_reset  in  1  reset; asynchronous, active-low
- all_finish  in  1  design finished; suppresses probing and detection
- blk_vec  in  N_PROC  per-process "blocked on any channel/sync" flag (OR of that process's dependency-valid bits)
- dl_in_vec  in  N_PROC  per-unit detect return (token came back to the unit)
- origin  out  N_PROC  one-hot probe origin, or zero when no probe is active
- token_clear  out  1  one-cycle pulse clearing all ring tokens
- dl_detect_out  out  1  sticky deadlock flag
- dl_proc  out  IDX_W  index of the origin that detected the deadlock
- probe_cnt  out  16  probes issued (see Configuration)
- timeout_cnt  out  16  probes ended by window expiry (see Configuration)

## Operation
- State machine states: IDLE, SELECT, PROBE, CLEAR, DETECTED. Round-robin pointer ptr ∈ [0, N_PROC-1]. Window timer tmr.
- IDLE
  - origin=0.
  - If all_finish=0 and |blk_vec=1, go to SELECT.
- SELECT (1 cycle)
  - pick = first set bit of blk_vec scanning ptr, ptr+1, … with wrap at N_PROC-1→0.
  - If none is set, go to IDLE.
  - Otherwise latch pick, set ptr=(pick+1) mod N_PROC, load tmr=PROBE_CYCLES-1, go to PROBE.
- PROBE
  - origin = one-hot(pick). tmr decrements each cycle.
  - Exit priority, highest first:
    - all_finish=1: go to CLEAR.
    - dl_in_vec[pick]=1: go to DETECTED.
    - blk_vec[pick]=0: go to CLEAR.
    - tmr=0: go to CLEAR and count a timeout.
  - dl_in_vec bits other than pick are ignored.
- CLEAR (1 cycle)
  - token_clear=1, origin=0, then go to IDLE.
- DETECTED (terminal until reset)
  - dl_detect_out=1, dl_proc=pick, origin held at one-hot(pick), token_clear=0.
  - all_finish is ignored once detected.
- Boundary conditions:
  - If blk_vec changes during SELECT, the value sampled in that cycle is used.
  - N_PROC=1: ptr stays 0.
  - If dl_in_vec[pick] and tmr=0 occur together, detection wins.
  - If all_finish and dl_in_vec[pick] occur together, all_finish wins (no detection).
  - Asserting reset mid-probe returns to IDLE immediately, with all outputs and ptr at 0.

## Timing
- All outputs are registered. Reset values: origin=0, token_clear=0, dl_detect_out=0, dl_proc=0, probe_cnt=0, timeout_cnt=0, ptr=0, state=IDLE.
- IDLE→SELECT→PROBE takes 2 cycles from the first blk_vec assertion. origin is valid on the cycle after SELECT.
- The probe window is exactly PROBE_CYCLES cycles with origin asserted. token_clear is asserted on the next cycle.
- dl_detect_out rises 1 cycle after dl_in_vec[pick] is sampled high in PROBE.
- Minimum interval between consecutive probes is 3 cycles (CLEAR, IDLE, SELECT).

## Configuration
- DL_PROBE_STATS_EN
  - Defined: probe_cnt increments on each SELECT→PROBE transition. timeout_cnt increments on each tmr-expiry exit. Both counters saturate at 16'hFFFF and reset to 0.
  - Undefined: both counters are removed and the probe_cnt/timeout_cnt ports are tied to 0. FSM behaviour is identical.

## Test plan
- Single blocked process: blk_vec=3'b010 held, dl_in_vec=0, PROBE_CYCLES=16 → origin=3'b010 for 16 cycles, then a 1-cycle token_clear, then a re-probe of process 1. With the macro defined, timeout_cnt=1 after the first window.
- Round-robin: blk_vec=3'b111 held → successive origins 3'b001, 3'b010, 3'b100, 3'b001, each followed by a token_clear pulse.
- Deadlock: blk_vec=3'b110, and dl_in_vec[1]=1 driven on the 5th PROBE cycle of process 1 → dl_detect_out=1 on the next cycle, dl_proc=1, origin held at 3'b010 and stays so with all inputs later deasserted.
- Unblock mid-probe: blk_vec[pick] drops at probe cycle 3 → CLEAR on the next cycle, token_clear=1, no timeout counted.
- all_finish: all_finish=1 together with dl_in_vec[pick]=1 during PROBE → token_clear pulse, dl_detect_out stays 0, no further probes while all_finish=1.
- Reset mid-probe: dl_reset low at probe cycle 7 → all outputs 0 asynchronously; after release, the first probe starts at process 0.
